// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around a 1-bit full adder
// Operands are consumed LSB-first, one bit per clock; the result is published on entry to DONE.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_bit;
    logic             c_next;

    // The full-adder cell; subtraction works as a + ~b + 1 via the preloaded carry.
    assign s_bit  = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
    assign c_next = (shift_a_q[0] & shift_b_q[0]) |
                    (shift_a_q[0] & carry_q) |
                    (shift_b_q[0] & carry_q);

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_a_d = a_i;
                    shift_b_d = sub_i ? ~b_i : b_i;
                    carry_d   = sub_i;
                    cnt_d     = '0;
                    acc_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                carry_d   = c_next;
                shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                acc_d     = {s_bit, acc_q[WIDTH-1:1]};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish straight from the adder so the MSB lands in the same edge.
                    sum_d   = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
